// File: rtl/parking_gate_controller.sv
// Parking lot gate sequencer: runs the entry and exit barriers, reserves the
// lowest free bay for each arriving car, releases the reservation when the
// car parks (or after a timeout) and reports free-space count / full flag.
module parking_gate_controller #(
  parameter int NSLOT        = 6,
  parameter int GATE_TICKS   = 50000000,
  parameter int PARK_TIMEOUT = 500000000,
  parameter int TW           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NSLOT-1:0] occupied,
  input  logic             entry_req,
  input  logic             exit_req,
  output logic             gate_in_open,
  output logic             gate_out_open,
  output logic [2:0]       assigned_slot,
  output logic             assigned_valid,
  output logic [NSLOT-1:0] reserved,
  output logic [3:0]       free_count,
  output logic             full,
  output logic             entry_denied,
  output logic             park_timeout
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ALLOC      = 3'd1,
    ENTRY_OPEN = 3'd2,
    WAIT_PARK  = 3'd3,
    EXIT_OPEN  = 3'd4
  } state_t;

  localparam logic [TW-1:0] GATE_LOAD = TW'(GATE_TICKS);
  localparam logic [TW-1:0] PARK_LOAD = TW'(PARK_TIMEOUT);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  state_t           state_r;
  logic [TW-1:0]    timer_r;
  logic             gate_in_r;
  logic             gate_out_r;
  logic [2:0]       slot_r;
  logic             valid_r;
  logic [NSLOT-1:0] reserved_r;
  logic [3:0]       count_r;
  logic             full_r;
  logic             denied_r;
  logic             timeout_r;

  logic [NSLOT-1:0] free_s;
  logic [NSLOT-1:0] pick_s;
  logic [2:0]       pick_idx_s;
  logic             occ_hit_s;

  // Number of set bits in a bay mask.
  function automatic logic [3:0] count_free(input logic [NSLOT-1:0] m);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < NSLOT; i++) begin
      c = c + {3'd0, m[i]};
    end
    return c;
  endfunction

  // Index of the lowest set bit in a bay mask (0 when the mask is empty).
  function automatic logic [2:0] lowest_index(input logic [NSLOT-1:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      idx = m[i] ? 3'(i) : idx;
    end
    return idx;
  endfunction

  // Free bays, lowest-free selection and occupancy of the reserved bay.
  always_comb begin
    free_s     = ~occupied & ~reserved_r;
    pick_s     = free_s & (~free_s + NSLOT'(1'b1));
    pick_idx_s = lowest_index(free_s);
    occ_hit_s  = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      occ_hit_s = (slot_r == 3'(i)) ? occupied[i] : occ_hit_s;
    end
  end

  // Gate sequencing FSM with countdown timer, reservation and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      timer_r    <= '0;
      gate_in_r  <= 1'b0;
      gate_out_r <= 1'b0;
      slot_r     <= 3'd0;
      valid_r    <= 1'b0;
      reserved_r <= '0;
      count_r    <= 4'd0;
      full_r     <= 1'b0;
      denied_r   <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      count_r   <= count_free(free_s);
      full_r    <= (free_s == {NSLOT{1'b0}});
      denied_r  <= 1'b0;
      timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // Exit wins over entry: it frees space.
          if (exit_req) begin
            state_r    <= EXIT_OPEN;
            timer_r    <= GATE_LOAD;
            gate_out_r <= 1'b1;
          end else if (entry_req && !full_r) begin
            state_r <= ALLOC;
          end else if (entry_req) begin
            denied_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        ALLOC: begin
          // The bay may have filled since IDLE saw space; then give up.
          if (free_s != {NSLOT{1'b0}}) begin
            reserved_r <= pick_s;
            slot_r     <= pick_idx_s;
            valid_r    <= 1'b1;
            gate_in_r  <= 1'b1;
            timer_r    <= GATE_LOAD;
            state_r    <= ENTRY_OPEN;
          end else begin
            state_r <= IDLE;
          end
        end
        ENTRY_OPEN: begin
          if (timer_r == TIMER_ONE) begin
            gate_in_r <= 1'b0;
            timer_r   <= PARK_LOAD;
            state_r   <= WAIT_PARK;
          end else begin
            timer_r <= timer_r - TIMER_ONE;
          end
        end
        WAIT_PARK: begin
          // Only the reserved bay filling releases the reservation.
          if (occ_hit_s) begin
            reserved_r <= '0;
            valid_r    <= 1'b0;
            timer_r    <= '0;
            state_r    <= IDLE;
          end else if (timer_r == TIMER_ONE) begin
            reserved_r <= '0;
            valid_r    <= 1'b0;
            timeout_r  <= 1'b1;
            timer_r    <= '0;
            state_r    <= IDLE;
          end else begin
            timer_r <= timer_r - TIMER_ONE;
          end
        end
        EXIT_OPEN: begin
          if (timer_r == TIMER_ONE) begin
            gate_out_r <= 1'b0;
            timer_r    <= '0;
            state_r    <= IDLE;
          end else begin
            timer_r <= timer_r - TIMER_ONE;
          end
        end
        default: begin
          state_r    <= IDLE;
          timer_r    <= '0;
          gate_in_r  <= 1'b0;
          gate_out_r <= 1'b0;
          valid_r    <= 1'b0;
          reserved_r <= '0;
        end
      endcase
    end
  end

  assign gate_in_open   = gate_in_r;
  assign gate_out_open  = gate_out_r;
  assign assigned_slot  = slot_r;
  assign assigned_valid = valid_r;
  assign reserved       = reserved_r;
  assign free_count     = count_r;
  assign full           = full_r;
  assign entry_denied   = denied_r;
  assign park_timeout   = timeout_r;

endmodule
